// File: rtl/calc_sb_pkg.sv
// Shared types for the calculator scoreboard: response codes, error causes
// and the controller state.
package calc_sb_pkg;

    localparam int RSP_NONE = 0;
    localparam int RSP_SUCC = 1;
    localparam int RSP_INOF = 2;
    localparam int RSP_IERR = 3;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_MISMATCH   = 3'd1,
        ERR_UNEXPECTED = 3'd2,
        ERR_OVERFLOW   = 3'd3,
        ERR_TIMEOUT    = 3'd4
    } err_cause_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_REPORT = 1'b1
    } sb_state_e;

endpackage

// File: rtl/calc_sb_port_queue.sv
// One port's expected-response FIFO with head-age timeout and DUV compare;
// reports at most one error cause per cycle.
module calc_sb_port_queue
    import calc_sb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RESP_W  = 2,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_ref_data,
    input  logic [RESP_W-1:0] i_ref_resp,
    input  logic [DATA_W-1:0] i_duv_data,
    input  logic [RESP_W-1:0] i_duv_resp,
    output err_cause_e        o_err,
    output logic              o_busy_next
);
    localparam int AW    = $clog2(DEPTH);
    localparam int AGE_W = $clog2(TIMEOUT + 1);
    localparam logic [RESP_W-1:0] L_NONE    = RESP_W'(RSP_NONE);
    localparam logic [RESP_W-1:0] L_SUCC    = RESP_W'(RSP_SUCC);
    localparam logic [AW:0]       L_DEPTH   = (AW + 1)'(DEPTH);
    localparam logic [AGE_W-1:0]  L_AGE_LIM = AGE_W'(TIMEOUT - 1);

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [RESP_W-1:0] r_resp [DEPTH];
    logic [AW-1:0]     r_rd_ptr, r_wr_ptr;
    logic [AW:0]       r_count;
    logic [AGE_W-1:0]  r_age;

    logic              w_push, w_pop, w_empty, w_full, w_bypass;
    logic              w_timeout, w_deq, w_store, w_match;
    logic [AW-1:0]     w_rd_base, w_wr_base;
    logic [AW:0]       w_count_next;
    logic [DATA_W-1:0] w_exp_data;
    logic [RESP_W-1:0] w_exp_resp;

    // A flush makes the queue look empty this cycle, so inputs sampled
    // alongside it are handled as the first traffic of the new test.
    always_comb begin
        w_push     = (i_ref_resp != L_NONE);
        w_pop      = (i_duv_resp != L_NONE);
        w_empty    = i_flush || (r_count == '0);
        w_full     = !i_flush && (r_count == L_DEPTH);
        w_rd_base  = i_flush ? '0 : r_rd_ptr;
        w_wr_base  = i_flush ? '0 : r_wr_ptr;
        w_bypass   = w_pop && w_empty && w_push;
        w_timeout  = !w_empty && !w_pop && (r_age == L_AGE_LIM);
        w_deq      = (!w_empty && w_pop) || w_timeout;
        w_store    = w_push && !w_bypass && (!w_full || w_deq);
        w_exp_data = w_bypass ? i_ref_data : r_data[w_rd_base];
        w_exp_resp = w_bypass ? i_ref_resp : r_resp[w_rd_base];
        w_match    = (w_exp_resp == i_duv_resp) &&
                     ((w_exp_resp != L_SUCC) || (w_exp_data == i_duv_data));

        o_err = ERR_NONE;
        if (w_pop && w_empty && !w_push)
            o_err = ERR_UNEXPECTED;
        else if (w_pop && !w_match)
            o_err = ERR_MISMATCH;
        else if (w_timeout)
            o_err = ERR_TIMEOUT;
        else if (w_push && !w_bypass && !w_store)
            o_err = ERR_OVERFLOW;

        w_count_next = (w_empty ? '0 : r_count) + (AW + 1)'(w_store) - (AW + 1)'(w_deq);
        o_busy_next  = (w_count_next != '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_age    <= '0;
        end else begin
            r_rd_ptr <= w_deq   ? w_rd_base + 1'b1 : w_rd_base;
            r_wr_ptr <= w_store ? w_wr_base + 1'b1 : w_wr_base;
            r_count  <= w_count_next;
            if (w_count_next == '0 || w_deq || (w_store && w_empty))
                r_age <= '0;
            else
                r_age <= r_age + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_store) begin
            r_data[w_wr_base] <= i_ref_data;
            r_resp[w_wr_base] <= i_ref_resp;
        end
    end

endmodule

// File: rtl/calc_scoreboard.sv
// Multi-port calculator scoreboard: per-port queues plus a RUN/REPORT
// controller that closes a test on every test_change edge.
module calc_scoreboard
    import calc_sb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int RESP_W    = 2,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 8
) (
    input  logic                        c_clk,
    input  logic                        reset,
    input  logic [NUM_PORTS*DATA_W-1:0] ref_out_data,
    input  logic [NUM_PORTS*RESP_W-1:0] ref_out_resp,
    input  logic [NUM_PORTS*DATA_W-1:0] duv_out_data,
    input  logic [NUM_PORTS*RESP_W-1:0] duv_out_resp,
    input  logic                        test_change,
    output logic                        test_done,
    output logic                        test_pass,
    output logic [NUM_PORTS-1:0]        err_port,
    output logic [CNT_W-1:0]            mismatch_cnt,
    output logic                        busy,
    output sb_state_e                   dbg_state
);
    localparam logic [CNT_W:0] L_CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    sb_state_e            r_state;
    logic                 r_tc;
    err_cause_e           w_cause [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_err, w_busy_next;
    logic                 w_flush, w_edge;
    logic [CNT_W:0]       w_sum;
    logic [CNT_W-1:0]     w_cnt_next;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        calc_sb_port_queue #(
            .DATA_W  (DATA_W),
            .RESP_W  (RESP_W),
            .DEPTH   (DEPTH),
            .TIMEOUT (TIMEOUT)
        ) u_queue (
            .i_clk       (c_clk),
            .i_rst       (reset),
            .i_flush     (w_flush),
            .i_ref_data  (ref_out_data[p*DATA_W +: DATA_W]),
            .i_ref_resp  (ref_out_resp[p*RESP_W +: RESP_W]),
            .i_duv_data  (duv_out_data[p*DATA_W +: DATA_W]),
            .i_duv_resp  (duv_out_resp[p*RESP_W +: RESP_W]),
            .o_err       (w_cause[p]),
            .o_busy_next (w_busy_next[p])
        );
        assign w_err[p] = (w_cause[p] != ERR_NONE);
    end

    assign dbg_state = r_state;

    always_comb begin
        w_flush    = (r_state == ST_REPORT);
        w_edge     = (test_change != r_tc);
        w_sum      = (w_flush ? '0 : {1'b0, mismatch_cnt}) + (CNT_W + 1)'($countones(w_err));
        w_cnt_next = (w_sum > L_CNT_MAX) ? L_CNT_MAX[CNT_W-1:0] : w_sum[CNT_W-1:0];
    end

    // r_tc is frozen in REPORT so an edge arriving there is seen again in RUN.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_tc         <= 1'b0;
            test_done    <= 1'b0;
            test_pass    <= 1'b0;
            err_port     <= '0;
            mismatch_cnt <= '0;
            busy         <= 1'b0;
        end else begin
            err_port     <= (w_flush ? '0 : err_port) | w_err;
            mismatch_cnt <= w_cnt_next;
            busy         <= |w_busy_next;
            test_done    <= 1'b0;
            test_pass    <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    r_tc <= test_change;
                    if (w_edge) begin
                        r_state   <= ST_REPORT;
                        test_done <= 1'b1;
                        test_pass <= (w_cnt_next == '0) && !(|w_busy_next);
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_scoreboard.sv
// Directed bench for calc_scoreboard with hand-computed expectations.
module tb_calc_scoreboard;
    import calc_sb_pkg::*;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int RW = 2;

    logic             c_clk = 1'b0;
    logic             reset = 1'b1;
    logic [NP*DW-1:0] ref_out_data = '0;
    logic [NP*RW-1:0] ref_out_resp = '0;
    logic [NP*DW-1:0] duv_out_data = '0;
    logic [NP*RW-1:0] duv_out_resp = '0;
    logic             test_change = 1'b0;
    logic             test_done, test_pass, busy;
    logic [NP-1:0]    err_port;
    logic [7:0]       mismatch_cnt;
    sb_state_e        dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    calc_scoreboard dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .ref_out_data (ref_out_data),
        .ref_out_resp (ref_out_resp),
        .duv_out_data (duv_out_data),
        .duv_out_resp (duv_out_resp),
        .test_change  (test_change),
        .test_done    (test_done),
        .test_pass    (test_pass),
        .err_port     (err_port),
        .mismatch_cnt (mismatch_cnt),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    always #5 c_clk = ~c_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic clear_in();
        ref_out_resp = '0;
        duv_out_resp = '0;
        ref_out_data = '0;
        duv_out_data = '0;
    endtask

    task automatic set_ref(input int p, input logic [31:0] d, input logic [1:0] r);
        ref_out_data[p*DW +: DW] = d;
        ref_out_resp[p*RW +: RW] = r;
    endtask

    task automatic set_duv(input int p, input logic [31:0] d, input logic [1:0] r);
        duv_out_data[p*DW +: DW] = d;
        duv_out_resp[p*RW +: RW] = r;
    endtask

    // One idle cycle with a test_change toggle; leaves the bench in REPORT.
    task automatic close_test();
        clear_in();
        test_change = ~test_change;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge c_clk);
        #1;
        check("rst_done", test_done, 0);
        check("rst_pass", test_pass, 0);
        check("rst_err", err_port, 0);
        check("rst_cnt", mismatch_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, ST_RUN);
        reset = 1'b0;
        step();
        check("rel_no_done", test_done, 0);

        // Matching SUCC response three cycles after the reference.
        set_ref(0, 32'h5, 2'd1); step(); clear_in();
        check("t1_busy", busy, 1);
        step(); step();
        set_duv(0, 32'h5, 2'd1); step(); clear_in();
        check("t1_busy_off", busy, 0);
        check("t1_err", err_port, 0);
        close_test();
        check("t1_done", test_done, 1);
        check("t1_pass", test_pass, 1);
        check("t1_cnt", mismatch_cnt, 0);
        check("t1_state", dbg_state, ST_REPORT);
        step();
        check("t1_done_pulse", test_done, 0);

        // Data mismatch on port 2.
        set_ref(2, 32'hA, 2'd1); step(); clear_in();
        step(); step();
        set_duv(2, 32'hB, 2'd1); step(); clear_in();
        check("t2_err", err_port, 4'b0100);
        check("t2_cnt", mismatch_cnt, 1);
        close_test();
        check("t2_done", test_done, 1);
        check("t2_pass", test_pass, 0);
        step();
        check("t2_err_clr", err_port, 0);
        check("t2_cnt_clr", mismatch_cnt, 0);

        // Non-success responses ignore data; same-cycle bypass compare.
        set_ref(1, 32'hFFFF_FFFF, 2'd2); step(); clear_in();
        set_duv(1, 32'h1234_5678, 2'd2); step(); clear_in();
        check("t3_err", err_port, 0);
        check("t3_busy", busy, 0);
        set_ref(1, 32'h7, 2'd1); set_duv(1, 32'h7, 2'd1); step(); clear_in();
        check("t3_bypass_err", err_port, 0);
        check("t3_bypass_busy", busy, 0);
        set_ref(3, 32'h7, 2'd1); set_duv(3, 32'h8, 2'd1); step(); clear_in();
        check("t3_bypass_mis", err_port, 4'b1000);
        close_test();
        check("t3_pass", test_pass, 0);
        step();

        // Timeout on port 3 exactly 16 cycles after the push.
        set_ref(3, 32'h1, 2'd1); step(); clear_in();
        repeat (15) step();
        check("t4_busy_pre", busy, 1);
        check("t4_err_pre", err_port, 0);
        step();
        check("t4_err", err_port, 4'b1000);
        check("t4_cnt", mismatch_cnt, 1);
        check("t4_busy", busy, 0);
        close_test();
        check("t4_pass", test_pass, 0);
        step();

        // Overflow on the fifth push, drain, then an unexpected response.
        for (int i = 1; i <= 4; i++) begin
            set_ref(0, 32'(i), 2'd1); step(); clear_in();
        end
        check("t5_full_err", err_port, 0);
        set_ref(0, 32'h5, 2'd1); step(); clear_in();
        check("t5_ovf_err", err_port, 4'b0001);
        check("t5_ovf_cnt", mismatch_cnt, 1);
        for (int i = 1; i <= 4; i++) begin
            set_duv(0, 32'(i), 2'd1); step(); clear_in();
        end
        check("t5_drain_cnt", mismatch_cnt, 1);
        check("t5_drain_busy", busy, 0);
        set_duv(0, 32'h9, 2'd1); step(); clear_in();
        check("t5_unexp_cnt", mismatch_cnt, 2);
        close_test();
        check("t5_done", test_done, 1);
        check("t5_pass", test_pass, 0);
        // Toggle and push during REPORT: both belong to the next test.
        test_change = ~test_change;
        set_ref(0, 32'h9, 2'd1);
        step(); clear_in();
        check("t5_rep_done", test_done, 0);
        check("t5_new_busy", busy, 1);
        check("t5_new_cnt", mismatch_cnt, 0);
        step();
        check("t5_queued_done", test_done, 1);
        check("t5_queued_pass", test_pass, 0);
        step();
        check("t5_flush_busy", busy, 0);

        // Mid-test reset discards queued entries and errors.
        test_change = 1'b0;
        set_ref(0, 32'h1, 2'd1); set_ref(1, 32'h2, 2'd1); set_duv(2, 32'h3, 2'd1);
        step(); clear_in();
        check("t6_busy", busy, 1);
        check("t6_cnt", mismatch_cnt, 1);
        reset = 1'b1;
        step();
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cnt", mismatch_cnt, 0);
        check("t6_rst_err", err_port, 0);
        check("t6_rst_done", test_done, 0);
        reset = 1'b0;
        step();
        check("t6_rel_done", test_done, 0);
        set_ref(0, 32'h3, 2'd1); step(); clear_in();
        set_duv(0, 32'h3, 2'd1); step(); clear_in();
        close_test();
        check("t6_done", test_done, 1);
        check("t6_pass", test_pass, 1);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_scoreboard.md
CALC_SCOREBOARD -- requirements
Module: calc_scoreboard

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of calculator ports checked.
REQ-002 Parameter DATA_W, default 32: out_data width per port.
REQ-003 Parameter RESP_W, default 2: out_resp width per port.
REQ-004 Parameter DEPTH, default 4: expected-response queue entries per port; power of two, at least 2.
REQ-005 Parameter TIMEOUT, default 16: maximum cycles an expected response may wait for the DUV.
REQ-006 Parameter CNT_W, default 8: width of the mismatch counter.
REQ-007 c_clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 ref_out_data  in  NUM_PORTS*DATA_W  reference-model data; port p occupies bits [p*DATA_W +: DATA_W], p from 0.
REQ-010 ref_out_resp  in  NUM_PORTS*RESP_W  reference-model responses, packed the same way.
REQ-011 duv_out_data  in  NUM_PORTS*DATA_W  DUV data, packed the same way.
REQ-012 duv_out_resp  in  NUM_PORTS*RESP_W  DUV responses, packed the same way.
REQ-013 test_change  in  1  level toggle from the driver; every edge marks a test boundary.
REQ-014 test_done  out  1  one-cycle pulse reporting the test just closed.
REQ-015 test_pass  out  1  verdict for the closed test; valid only while test_done=1.
REQ-016 err_port  out  NUM_PORTS  sticky per-port error flags for the current test.
REQ-017 mismatch_cnt  out  CNT_W  saturating error count for the current test.
REQ-018 busy  out  1  high while any port queue is non-empty.

Function
REQ-019 Each cycle, per port, a ref resp other than RSP_NONE pushes {data,resp} into that port's FIFO queue.
REQ-020 Each cycle, per port, a DUV resp other than RSP_NONE pops the queue head and compares against it.
- resp must match exactly.
- data is compared only when the expected resp is RSP_SUCC.
REQ-021 A DUV resp arriving while the queue is empty, but with a same-cycle ref push on that port, bypasses the queue: the two are compared directly and nothing is stored.
REQ-022 A DUV resp arriving while the queue is empty with no same-cycle ref push is an "unexpected" error.
REQ-023 A push into a full queue is an "overflow" error; the new entry is dropped, except when a pop occurs in the same cycle, in which case the push succeeds.
REQ-024 Each port keeps a head-age counter.
- Counter clears on a pop or when a new head arrives, otherwise increments while the queue is non-empty.
- Reaching TIMEOUT is a "timeout" error and the head is discarded.
REQ-025 Any error on port p sets err_port[p].
REQ-026 mismatch_cnt adds the number of erroring ports in each cycle and saturates at all-ones.
REQ-027 The controller FSM has two states, RUN and REPORT.
- RUN to REPORT: a test_change edge is detected, i.e. test_change differs from its registered value.
- REPORT to RUN: unconditionally after one cycle.
REQ-028 In REPORT:
- test_done=1.
- test_pass=1 iff mismatch_cnt==0 and all queues were empty at the boundary.
REQ-029 Errors raised in the boundary cycle count toward the closing test.
REQ-030 On leaving REPORT, err_port and mismatch_cnt clear and all queues flush.
- Inputs sampled in the REPORT cycle belong to the new test and are processed normally after the flush.
REQ-031 A test_change edge while in REPORT is queued and closes the next test at the first RUN cycle.
REQ-032 Output latency: err_port, mismatch_cnt and busy update on the clock edge after the offending inputs are sampled.

Reset
REQ-033 During reset:
- FSM is in RUN.
- queues are empty; age counters are 0.
- test_done, test_pass, err_port and mismatch_cnt are all 0.
- the registered test_change is 0.
REQ-034 The driver holds test_change at 0 while reset is high, so no boundary is reported on release.
REQ-035 Reset asserted mid-test discards all queued entries and errors without pulsing test_done.

Structure
REQ-036 Package calc_sb_pkg holds:
- response constants RSP_NONE=0, RSP_SUCC=1, RSP_INOF=2, RSP_IERR=3.
- the error-cause encoding: none, mismatch, unexpected, overflow, timeout.
- the FSM state type.
REQ-037 Sub-module calc_sb_port_queue, one instance per port via generate, holds:
- the FIFO, age counter, bypass compare and error-cause output.
- the top level holds the FSM, counters and port unpacking.

Verification
REQ-038 Port 0 ref {0x00000005,1} at cycle 10, DUV {0x00000005,1} at cycle 13, then toggle test_change -> test_done pulse with test_pass=1, mismatch_cnt=0.
REQ-039 Port 2 ref {0x0000000A,1}, DUV {0x0000000B,1} three cycles later -> err_port=4'b0100, mismatch_cnt=1, test_pass=0 at boundary.
REQ-040 Port 1 ref {0xFFFFFFFF,2}, DUV {0x12345678,2} -> no error, because data is ignored for non-success responses.
REQ-041 Port 3 ref {0x1,1} with no DUV response -> timeout error exactly TIMEOUT=16 cycles after the push; busy falls in the same cycle.
REQ-042 Port 0:
- five ref pushes with no pops and DEPTH=4 -> overflow error on the fifth push, mismatch_cnt=1.
- DUV {resp=1} on an empty queue with no same-cycle ref push -> unexpected error, mismatch_cnt=2.
REQ-043 Run with ports 0 and 1 each carrying one queued entry; assert reset mid-test -> queues empty, counters 0, no test_done; a later clean test passes.
